// File: rtl/scrambler_multilane.sv
// Multi-lane 23-bit Galois scrambler with valid/ready handshake, per-beat bypass and LFSR reseed.
// Optional build macro SCRAM_DBG_EN exposes the per-lane LFSR state on lfsr_state.
module scrambler_multilane #(
  parameter int LANES     = 4,
  parameter int DATA_W    = 8,
  parameter int LANE_BASE = 0
) (
  input  logic                    clk_1G,
  input  logic                    rst_1G,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_bypass,
  input  logic                    in_lfsr_rst,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_bypass
`ifdef SCRAM_DBG_EN
  ,
  output logic [LANES*23-1:0]     lfsr_state
`endif
);

  function automatic logic [22:0] seed_for(input logic [2:0] idx);
    logic [22:0] s;
    case (idx)
      3'd0:    s = 23'h1DBFBC;
      3'd1:    s = 23'h0607BB;
      3'd2:    s = 23'h1EC760;
      3'd3:    s = 23'h18C0DB;
      3'd4:    s = 23'h010F12;
      3'd5:    s = 23'h19CFC9;
      3'd6:    s = 23'h0277CE;
      default: s = 23'h1BB807;
    endcase
    return s;
  endfunction

  // One step of X^23+X^21+X^16+X^8+X^5+X^2+1 in Galois form.
  function automatic logic [22:0] lfsr_step(input logic [22:0] lr);
    return {lr[21], lr[22] ^ lr[20], lr[19:16], lr[22] ^ lr[15], lr[14:8],
            lr[22] ^ lr[7], lr[6:5], lr[22] ^ lr[4], lr[3:2], lr[22] ^ lr[1],
            lr[0], lr[22]};
  endfunction

  logic                    accept;
  logic                    pass_through;
  logic [LANES*DATA_W-1:0] scr_data;

  logic                    out_valid_q, out_valid_d;
  logic [LANES*DATA_W-1:0] out_data_q, out_data_d;
  logic                    out_bypass_q, out_bypass_d;

  assign in_ready     = !out_valid_q | out_ready;
  assign accept       = in_valid & in_ready;
  assign pass_through = in_bypass | in_lfsr_rst;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [22:0] SEED = seed_for(3'((LANE_BASE + gi) % 8));

      logic [22:0]       lfsr_q, lfsr_d;
      logic [22:0]       lfsr_adv;
      logic [22:0]       lr;
      logic [DATA_W-1:0] ks;

      // Keystream bit k is the MSB before step k; the whole beat is unrolled.
      always_comb begin
        lr = lfsr_q;
        ks = '0;
        for (int k = 0; k < DATA_W; k++) begin
          ks[k] = lr[22];
          lr    = lfsr_step(lr);
        end
        lfsr_adv = lr;
      end

      assign scr_data[gi*DATA_W +: DATA_W] = in_data[gi*DATA_W +: DATA_W] ^ ks;

      always_comb begin
        lfsr_d = lfsr_q;
        if (accept) begin
          if (in_lfsr_rst) begin
            lfsr_d = SEED;
          end else if (!in_bypass) begin
            lfsr_d = lfsr_adv;
          end
        end
      end

      always_ff @(posedge clk_1G or posedge rst_1G) begin
        if (rst_1G) begin
          lfsr_q <= SEED;
        end else begin
          lfsr_q <= lfsr_d;
        end
      end

`ifdef SCRAM_DBG_EN
      assign lfsr_state[gi*23 +: 23] = lfsr_q;
`endif
    end
  endgenerate

  // A held beat keeps its data; valid drops only when drained with nothing new arriving.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_bypass_d = out_bypass_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_data_d   = pass_through ? in_data : scr_data;
      out_bypass_d = pass_through;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_1G or posedge rst_1G) begin
    if (rst_1G) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_bypass_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_bypass_q <= out_bypass_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_bypass = out_bypass_q;

endmodule
